// File: rtl/mypackage.sv
// Shared synth types: NCO frequency word, note key, and voice allocator state/selection enums.
package mypackage;

    localparam int unsigned FREQUENCY_BITS            = 32;
    localparam int unsigned FREQUENCY_FRACTIONAL_BITS = 8;

    typedef logic [FREQUENCY_BITS-1:0] frequency;
    typedef logic [6:0]                key_t;

    typedef enum logic {
        IDLE,
        RETRIG
    } voice_state_t;

    typedef enum logic [1:0] {
        SEL_RETRIG,
        SEL_FREE,
        SEL_OLDEST_FREE,
        SEL_STEAL
    } select_case_t;

endpackage

// File: rtl/voice_select.sv
// Key-down voice choice: retrigger match, idle voice, oldest released voice, oldest gated voice.
module voice_select
    import mypackage::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned KEY_BITS   = 7,
    parameter int unsigned AGE_BITS   = 8
) (
    input  logic [NUM_VOICES-1:0]               gate_i,
    input  logic [NUM_VOICES-1:0]               active_i,
    input  logic [NUM_VOICES-1:0][KEY_BITS-1:0] key_i,
    input  logic [NUM_VOICES-1:0][AGE_BITS-1:0] age_i,
    input  logic [KEY_BITS-1:0]                 note_key_i,
    output logic [$clog2(NUM_VOICES)-1:0]       index_o,
    output select_case_t                        case_o
);

    localparam int unsigned IDX_BITS = $clog2(NUM_VOICES);

    logic                match_found, idle_found, free_found, gated_found;
    logic [IDX_BITS-1:0] match_idx, idle_idx, free_idx, gated_idx;
    logic [AGE_BITS-1:0] free_age, gated_age;

    always_comb begin
        match_found = 1'b0;
        idle_found  = 1'b0;
        free_found  = 1'b0;
        gated_found = 1'b0;
        match_idx   = '0;
        idle_idx    = '0;
        free_idx    = '0;
        gated_idx   = '0;
        free_age    = '0;
        gated_age   = '0;
        index_o     = '0;
        case_o      = SEL_STEAL;

        // Strict '>' keeps the lowest index on equal ages.
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (gate_i[i]) begin
                if (!match_found && key_i[i] == note_key_i) begin
                    match_found = 1'b1;
                    match_idx   = IDX_BITS'(i);
                end
                if (!gated_found || age_i[i] > gated_age) begin
                    gated_found = 1'b1;
                    gated_idx   = IDX_BITS'(i);
                    gated_age   = age_i[i];
                end
            end else begin
                if (!idle_found && !active_i[i]) begin
                    idle_found = 1'b1;
                    idle_idx   = IDX_BITS'(i);
                end
                if (!free_found || age_i[i] > free_age) begin
                    free_found = 1'b1;
                    free_idx   = IDX_BITS'(i);
                    free_age   = age_i[i];
                end
            end
        end

        if (match_found) begin
            index_o = match_idx;
            case_o  = SEL_RETRIG;
        end else if (idle_found) begin
            index_o = idle_idx;
            case_o  = SEL_FREE;
        end else if (free_found) begin
            index_o = free_idx;
            case_o  = SEL_OLDEST_FREE;
        end else begin
            index_o = gated_idx;
            case_o  = SEL_STEAL;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: note events in, per-voice gate/frequency/key out.
module voice_allocator
    import mypackage::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned KEY_BITS   = 7,
    parameter int unsigned AGE_BITS   = 8
) (
    input  logic                                audio_clock,
    input  logic                                reset,
    input  logic                                note_valid,
    output logic                                note_ready,
    input  logic                                note_on,
    input  logic [KEY_BITS-1:0]                 note_key,
    input  frequency                            note_freq,
    input  logic [NUM_VOICES-1:0]               voice_active,
    output logic [NUM_VOICES-1:0]               voice_gate,
    output frequency [NUM_VOICES-1:0]           voice_freq,
    output logic [NUM_VOICES-1:0][KEY_BITS-1:0] voice_key,
    output logic                                stolen
);

    localparam int unsigned IDX_BITS = $clog2(NUM_VOICES);

    voice_state_t                         state_q, state_d;
    logic                                 note_ready_q, note_ready_d;
    logic [NUM_VOICES-1:0]                gate_q, gate_d;
    frequency [NUM_VOICES-1:0]            freq_q, freq_d;
    logic [NUM_VOICES-1:0][KEY_BITS-1:0]  key_q, key_d;
    logic [NUM_VOICES-1:0][AGE_BITS-1:0]  age_q, age_d;
    logic                                 stolen_q, stolen_d;
    logic [IDX_BITS-1:0]                  pend_q, pend_d;

    logic                                 ev_valid_q, ev_valid_d;
    logic                                 ev_on_q, ev_on_d;
    logic [KEY_BITS-1:0]                  ev_key_q, ev_key_d;
    frequency                             ev_freq_q, ev_freq_d;

    logic [IDX_BITS-1:0]                  sel_idx;
    select_case_t                         sel_case;

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .KEY_BITS   (KEY_BITS),
        .AGE_BITS   (AGE_BITS)
    ) u_voice_select (
        .gate_i     (gate_q),
        .active_i   (voice_active),
        .key_i      (key_q),
        .age_i      (age_q),
        .note_key_i (ev_key_q),
        .index_o    (sel_idx),
        .case_o     (sel_case)
    );

    // Events are captured on acceptance and applied on the following edge;
    // the capture register is only held while RETRIG blocks new acceptances.
    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        freq_d     = freq_q;
        key_d      = key_q;
        age_d      = age_q;
        pend_d     = pend_q;
        stolen_d   = 1'b0;
        ev_valid_d = ev_valid_q;
        ev_on_d    = ev_on_q;
        ev_key_d   = ev_key_q;
        ev_freq_d  = ev_freq_q;

        unique case (state_q)
            IDLE: begin
                if (ev_valid_q) begin
                    ev_valid_d = 1'b0;
                    if (ev_on_q) begin
                        freq_d[sel_idx] = ev_freq_q;
                        key_d[sel_idx]  = ev_key_q;
                        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_BITS'(i) == sel_idx)
                                age_d[i] = '0;
                            else if (age_q[i] != '1)
                                age_d[i] = age_q[i] + 1'b1;
                        end
                        if (sel_case == SEL_RETRIG || sel_case == SEL_STEAL) begin
                            gate_d[sel_idx] = 1'b0;
                            pend_d          = sel_idx;
                            state_d         = RETRIG;
                            stolen_d        = (sel_case == SEL_STEAL);
                        end else begin
                            gate_d[sel_idx] = 1'b1;
                        end
                    end else if (sel_case == SEL_RETRIG) begin
                        gate_d[sel_idx] = 1'b0;
                    end
                end
            end
            RETRIG: begin
                gate_d[pend_q] = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (note_valid && note_ready_q) begin
            ev_valid_d = 1'b1;
            ev_on_d    = note_on;
            ev_key_d   = note_key;
            ev_freq_d  = note_freq;
        end

        note_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge audio_clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            note_ready_q <= 1'b1;
            gate_q       <= '0;
            freq_q       <= '0;
            key_q        <= '0;
            age_q        <= '1;
            stolen_q     <= 1'b0;
            pend_q       <= '0;
            ev_valid_q   <= 1'b0;
            ev_on_q      <= 1'b0;
            ev_key_q     <= '0;
            ev_freq_q    <= '0;
        end else begin
            state_q      <= state_d;
            note_ready_q <= note_ready_d;
            gate_q       <= gate_d;
            freq_q       <= freq_d;
            key_q        <= key_d;
            age_q        <= age_d;
            stolen_q     <= stolen_d;
            pend_q       <= pend_d;
            ev_valid_q   <= ev_valid_d;
            ev_on_q      <= ev_on_d;
            ev_key_q     <= ev_key_d;
            ev_freq_q    <= ev_freq_d;
        end
    end

    assign note_ready = note_ready_q;
    assign voice_gate = gate_q;
    assign voice_freq = freq_q;
    assign voice_key  = key_q;
    assign stolen     = stolen_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with NUM_VOICES=4 and hand-computed expectations.
module tb_voice_allocator;
    import mypackage::*;

    localparam int unsigned NV = 4;
    localparam int unsigned KB = 7;
    localparam int unsigned AB = 8;

    logic                  audio_clock = 1'b0;
    logic                  reset;
    logic                  note_valid;
    logic                  note_ready;
    logic                  note_on;
    logic [KB-1:0]         note_key;
    frequency              note_freq;
    logic [NV-1:0]         voice_active;
    logic [NV-1:0]         voice_gate;
    frequency [NV-1:0]     voice_freq;
    logic [NV-1:0][KB-1:0] voice_key;
    logic                  stolen;

    int checks   = 0;
    int failures = 0;

    voice_allocator #(
        .NUM_VOICES (NV),
        .KEY_BITS   (KB),
        .AGE_BITS   (AB)
    ) dut (
        .audio_clock  (audio_clock),
        .reset        (reset),
        .note_valid   (note_valid),
        .note_ready   (note_ready),
        .note_on      (note_on),
        .note_key     (note_key),
        .note_freq    (note_freq),
        .voice_active (voice_active),
        .voice_gate   (voice_gate),
        .voice_freq   (voice_freq),
        .voice_key    (voice_key),
        .stolen       (stolen)
    );

    always #5 audio_clock = ~audio_clock;

    function automatic frequency hz(input int unsigned h);
        return frequency'(h) << FREQUENCY_FRACTIONAL_BITS;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        note_valid   = 1'b0;
        voice_active = '0;
        reset        = 1'b1;
        @(negedge audio_clock);
        @(negedge audio_clock);
        reset = 1'b0;
    endtask

    // Presents one event from a negedge; returns at the negedge after the acceptance edge.
    task automatic send(input logic on, input int unsigned key, input frequency f);
        int n = 0;
        while (!note_ready && n < 20) begin
            @(negedge audio_clock);
            n++;
        end
        if (!note_ready) check("ready_timeout", 64'(note_ready), 64'd1);
        note_valid = 1'b1;
        note_on    = on;
        note_key   = KB'(key);
        note_freq  = f;
        @(negedge audio_clock);
        note_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        note_valid   = 1'b0;
        note_on      = 1'b0;
        note_key     = '0;
        note_freq    = '0;
        voice_active = '0;

        // Reset state
        repeat (2) @(negedge audio_clock);
        check("rst_gate",   64'(voice_gate), 64'h0);
        check("rst_freq0",  64'(voice_freq[0]), 64'h0);
        check("rst_key",    64'(voice_key), 64'h0);
        check("rst_stolen", 64'(stolen), 64'h0);
        reset = 1'b0;
        @(negedge audio_clock);
        check("rst_ready", 64'(note_ready), 64'h1);

        // Key down to a free voice
        send(1'b1, 60, hz(440));
        check("kd_gate_n",  64'(voice_gate), 64'h0);
        check("kd_ready_n", 64'(note_ready), 64'h1);
        @(negedge audio_clock);
        check("kd_gate",  64'(voice_gate), 64'h1);
        check("kd_freq0", 64'(voice_freq[0]), 64'(hz(440)));
        check("kd_key0",  64'(voice_key[0]), 64'd60);
        check("kd_ready", 64'(note_ready), 64'h1);

        // Fill all voices, then steal the oldest (voice 0)
        send(1'b1, 62, hz(294)); @(negedge audio_clock);
        check("fill_gate1", 64'(voice_gate), 64'h3);
        send(1'b1, 64, hz(330)); @(negedge audio_clock);
        check("fill_gate2", 64'(voice_gate), 64'h7);
        send(1'b1, 65, hz(349)); @(negedge audio_clock);
        check("fill_gate3", 64'(voice_gate), 64'hf);
        send(1'b1, 67, hz(392));
        @(negedge audio_clock);
        check("st_gate",   64'(voice_gate), 64'he);
        check("st_stolen", 64'(stolen), 64'h1);
        check("st_ready",  64'(note_ready), 64'h0);
        check("st_key0",   64'(voice_key[0]), 64'd67);
        check("st_freq0",  64'(voice_freq[0]), 64'(hz(392)));
        voice_active = '1;
        @(negedge audio_clock);
        check("st_gate2",   64'(voice_gate), 64'hf);
        check("st_stolen2", 64'(stolen), 64'h0);
        check("st_ready2",  64'(note_ready), 64'h1);
        check("st_key1",    64'(voice_key[1]), 64'd62);
        voice_active = '0;

        // Key up, matched and unmatched
        do_reset();
        send(1'b1, 60, hz(440)); @(negedge audio_clock);
        send(1'b0, 60, '0);      @(negedge audio_clock);
        check("ku_gate",  64'(voice_gate), 64'h0);
        check("ku_key0",  64'(voice_key[0]), 64'd60);
        check("ku_freq0", 64'(voice_freq[0]), 64'(hz(440)));
        send(1'b0, 61, '0);      @(negedge audio_clock);
        check("ku61_gate",   64'(voice_gate), 64'h0);
        check("ku61_key0",   64'(voice_key[0]), 64'd60);
        check("ku61_stolen", 64'(stolen), 64'h0);
        check("ku61_ready",  64'(note_ready), 64'h1);

        // Same key twice retriggers voice 0
        do_reset();
        send(1'b1, 60, hz(440)); @(negedge audio_clock);
        send(1'b1, 60, hz(440));
        @(negedge audio_clock);
        check("rt_gate",   64'(voice_gate), 64'h0);
        check("rt_ready",  64'(note_ready), 64'h0);
        check("rt_stolen", 64'(stolen), 64'h0);
        @(negedge audio_clock);
        check("rt_gate2",  64'(voice_gate), 64'h1);
        check("rt_ready2", 64'(note_ready), 64'h1);

        // Releasing voice skipped in favour of a silent one; then oldest released voice
        do_reset();
        send(1'b1, 60, hz(440)); @(negedge audio_clock);
        send(1'b0, 60, '0);      @(negedge audio_clock);
        voice_active = 4'b0001;
        send(1'b1, 64, hz(330)); @(negedge audio_clock);
        check("act_gate", 64'(voice_gate), 64'h2);
        check("act_key1", 64'(voice_key[1]), 64'd64);
        voice_active = 4'b1111;
        send(1'b0, 64, '0);      @(negedge audio_clock);
        check("act_rel", 64'(voice_gate), 64'h0);
        send(1'b1, 67, hz(392)); @(negedge audio_clock);
        check("old_gate", 64'(voice_gate), 64'h4);
        check("old_key2", 64'(voice_key[2]), 64'd67);

        // Reset during RETRIG abandons the retrigger
        do_reset();
        send(1'b1, 60, hz(440)); @(negedge audio_clock);
        send(1'b1, 60, hz(440)); @(negedge audio_clock);
        check("rr_ready_rt", 64'(note_ready), 64'h0);
        reset = 1'b1;
        #1;
        check("rr_gate_async", 64'(voice_gate), 64'h0);
        @(negedge audio_clock);
        reset = 1'b0;
        @(negedge audio_clock);
        check("rr_gate",  64'(voice_gate), 64'h0);
        check("rr_ready", 64'(note_ready), 64'h1);
        @(negedge audio_clock);
        check("rr_gate2", 64'(voice_gate), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
